// File: rtl/hs_pkg.sv
// Shared types and constants for the 4-phase REQ/ACK word interface.
// Latency: n/a (types and constants only).
// Backpressure: n/a; used by the initiator now and by the responder side later.
package hs_pkg;

  // Handshake FSM states, shared by the source and the future sink.
  typedef enum logic [2:0] {
    IDLE,
    PRECHK,
    WAITHI,
    WAITLO,
    DONE,
    ERR
  } hs_state_t;

  // Wire levels of the handshake signals, named so FSM code reads as protocol.
  localparam logic REQ_ASSERT = 1'b1;
  localparam logic REQ_IDLE   = 1'b0;
  localparam logic ACK_HIGH   = 1'b1;
  localparam logic ACK_LOW    = 1'b0;

endpackage

// File: rtl/hs_timeout_counter.sv
// Per-phase watchdog: counts enabled cycles since the last clear.
// Latency: expired is combinational, high in the timeout_cycles-th enabled cycle.
// Backpressure: none; it saturates at the limit until cleared.
module hs_timeout_counter #(
  parameter int timeout_cycles = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);
  localparam logic [CW-1:0] LIMIT = CW'(timeout_cycles - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A phase has waited long enough once the counter sits at the limit
  // while the caller is still waiting.
  assign expired = en && (cnt_q == LIMIT);

  // Next count: restart on clear, advance while waiting, hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/req_ack_source.sv
// 4-phase REQ/ACK initiator: emits a burst of count words seed, seed+1, ...
// Latency: start at edge N -> REQ high after N+1; one word per two responder turnarounds.
// Backpressure: waits on the ACK level in every phase; a stuck phase ends in ERR.
module req_ack_source
  import hs_pkg::*;
#(
  parameter int bit_width      = 8,
  parameter int cnt_width      = 16,
  parameter int timeout_cycles = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cnt_width-1:0] count,
  input  logic [bit_width-1:0] seed,
  output logic                 dOutREQ,
  input  logic                 dOutACK,
  output logic [bit_width-1:0] dOUT,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [cnt_width-1:0] words_sent
);

  hs_state_t state_q, state_d;

  logic                 req_q,   req_d;
  logic [bit_width-1:0] dout_q,  dout_d;
  logic [cnt_width-1:0] ws_q,    ws_d;
  logic [cnt_width-1:0] count_q, count_d;
  logic [bit_width-1:0] seed_q,  seed_d;
  logic                 terr_q,  terr_d;

  logic phase_wait;
  logic phase_clr;
  logic phase_expired;
  logic [cnt_width-1:0] ws_inc;

  // Only the three ACK-waiting states are subject to the watchdog, and each
  // state entry starts a fresh phase.
  assign phase_wait = (state_q == PRECHK) || (state_q == WAITHI) || (state_q == WAITLO);
  assign phase_clr  = (state_d != state_q);
  assign ws_inc     = ws_q + 1'b1;

  hs_timeout_counter #(
    .timeout_cycles(timeout_cycles)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (phase_clr),
    .en     (phase_wait),
    .expired(phase_expired)
  );

  // Next-state and datapath updates; REQ and dOUT only move together so that
  // dOUT is already stable in the cycle REQ becomes visible.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dout_d  = dout_q;
    ws_d    = ws_q;
    count_d = count_q;
    seed_d  = seed_q;
    terr_d  = terr_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = count;
          seed_d  = seed;
          ws_d    = '0;
          terr_d  = 1'b0;
          state_d = PRECHK;
        end
      end

      PRECHK: begin
        if (count_q == '0) begin
          state_d = DONE;
        end else if (dOutACK == ACK_LOW) begin
          req_d   = REQ_ASSERT;
          dout_d  = seed_q;
          state_d = WAITHI;
        end else if (phase_expired) begin
          // Responder never released a stale ACK.
          req_d   = REQ_IDLE;
          terr_d  = 1'b1;
          state_d = ERR;
        end
      end

      WAITHI: begin
        if (dOutACK == ACK_HIGH) begin
          req_d   = REQ_IDLE;
          state_d = WAITLO;
        end else if (phase_expired) begin
          req_d   = REQ_IDLE;
          terr_d  = 1'b1;
          state_d = ERR;
        end
      end

      WAITLO: begin
        if (dOutACK == ACK_LOW) begin
          ws_d = ws_inc;
          if (ws_inc == count_q) begin
            state_d = DONE;
          end else begin
            req_d   = REQ_ASSERT;
            dout_d  = dout_q + 1'b1;
            state_d = WAITHI;
          end
        end else if (phase_expired) begin
          // A second ACK rise here is not a new handshake; it only stalls us.
          req_d   = REQ_IDLE;
          terr_d  = 1'b1;
          state_d = ERR;
        end
      end

      DONE: begin
        // A start arriving here is deliberately dropped.
        state_d = IDLE;
      end

      ERR: begin
        req_d   = REQ_IDLE;
        state_d = IDLE;
      end

      default: begin
        req_d   = REQ_IDLE;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops REQ at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= REQ_IDLE;
      dout_q  <= '0;
      ws_q    <= '0;
      count_q <= '0;
      seed_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
      ws_q    <= ws_d;
      count_q <= count_d;
      seed_q  <= seed_d;
      terr_q  <= terr_d;
    end
  end

  assign dOutREQ     = req_q;
  assign dOUT        = dout_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign timeout_err = terr_q;
  assign words_sent  = ws_q;

endmodule

// File: tb/tb_req_ack_source.sv
// Directed bench for req_ack_source with a behavioural 4-phase responder.
// Latency: responder answers on the falling edge after each REQ change.
// Backpressure: responder can be disabled and ACK forced to a fixed level.
module tb_req_ack_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic [7:0]  seed = '0;
  logic        dOutREQ;
  logic        dOutACK = 1'b0;
  logic [7:0]  dOUT;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [15:0] words_sent;

  int checks = 0;
  int errors = 0;

  logic       resp_en = 1'b0;
  logic       ack_force = 1'b0;
  logic [7:0] words[$];
  int         done_cnt = 0;
  int         req_rise = 0;
  logic       req_prev = 1'b0;

  req_ack_source #(
    .bit_width(8),
    .cnt_width(16),
    .timeout_cycles(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .count      (count),
    .seed       (seed),
    .dOutREQ    (dOutREQ),
    .dOutACK    (dOutACK),
    .dOUT       (dOUT),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  // Responder: mirrors REQ on the falling edge and records each word it accepts.
  always @(negedge clk) begin
    if (resp_en) begin
      if (dOutREQ && !dOutACK) words.push_back(dOUT);
      dOutACK = dOutREQ;
    end else begin
      dOutACK = ack_force;
    end
  end

  // Event monitors for done pulses and REQ rising edges.
  always @(negedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (dOutREQ && !req_prev) req_rise = req_rise + 1;
    req_prev = dOutREQ;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wq(input int i);
    if (i < words.size()) return {24'h0, words[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] c, input logic [7:0] s);
    tick();
    start = 1'b1;
    count = c;
    seed  = s;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt != 0), 32'd1);
    tick();
  endtask

  initial begin
    int n;
    int hi;

    // Reset values
    repeat (3) tick();
    check("rst_req",   32'(dOutREQ),     32'd0);
    check("rst_dout",  32'(dOUT),        32'h00);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_terr",  32'(timeout_err), 32'd0);
    check("rst_ws",    32'(words_sent),  32'd0);
    rst = 1'b0;

    // 1. Burst seed=0x10, count=3 with latency checks
    resp_en = 1'b1;
    words.delete();
    done_cnt = 0;
    do_start(16'd3, 8'h10);
    check("b1_busy_prechk", 32'(busy),    32'd1);
    check("b1_req_prechk",  32'(dOutREQ), 32'd0);
    tick();
    check("b1_req_first",   32'(dOutREQ), 32'd1);
    check("b1_dout_first",  32'(dOUT),    32'h10);
    wait_done("b1_done_seen", 40);
    check("b1_nwords", 32'(words.size()), 32'd3);
    check("b1_w0", wq(0), 32'h10);
    check("b1_w1", wq(1), 32'h11);
    check("b1_w2", wq(2), 32'h12);
    check("b1_ws",    32'(words_sent),  32'd3);
    check("b1_ndone", 32'(done_cnt),    32'd1);
    check("b1_terr",  32'(timeout_err), 32'd0);
    check("b1_idle",  32'(busy),        32'd0);

    // 2. Wrap seed=0xFE, count=3
    words.delete();
    done_cnt = 0;
    do_start(16'd3, 8'hFE);
    wait_done("b2_done_seen", 40);
    check("b2_nwords", 32'(words.size()), 32'd3);
    check("b2_w0", wq(0), 32'hFE);
    check("b2_w1", wq(1), 32'hFF);
    check("b2_w2", wq(2), 32'h00);
    check("b2_ws",    32'(words_sent), 32'd3);
    check("b2_ndone", 32'(done_cnt),   32'd1);

    // 3. Zero-length burst: done two cycles after start, no REQ
    words.delete();
    done_cnt = 0;
    req_rise = 0;
    do_start(16'd0, 8'h55);
    check("z_done_early", 32'(done), 32'd0);
    tick();
    check("z_done_pulse", 32'(done), 32'd1);
    tick();
    check("z_done_drop",  32'(done),       32'd0);
    check("z_busy",       32'(busy),       32'd0);
    check("z_req_rises",  32'(req_rise),   32'd0);
    check("z_ws",         32'(words_sent), 32'd0);

    // 4. Timeout: ACK held low, REQ must stay high exactly 16 cycles
    resp_en = 1'b0;
    ack_force = 1'b0;
    done_cnt = 0;
    do_start(16'd2, 8'h20);
    hi = 0;
    n = 0;
    while (!(hi > 0 && !dOutREQ) && n < 60) begin
      tick();
      if (dOutREQ) hi++;
      n++;
    end
    check("to_req_cycles", 32'(hi),          32'd16);
    check("to_req_low",    32'(dOutREQ),     32'd0);
    check("to_err_busy",   32'(busy),        32'd1);
    check("to_terr",       32'(timeout_err), 32'd1);
    tick();
    check("to_idle",       32'(busy),        32'd0);
    check("to_terr_stick", 32'(timeout_err), 32'd1);
    check("to_ws",         32'(words_sent),  32'd0);
    check("to_ndone",      32'(done_cnt),    32'd0);

    // 5. Stale ACK at start; a second start while busy is ignored
    ack_force = 1'b1;
    tick();
    words.delete();
    done_cnt = 0;
    do_start(16'd2, 8'h40);
    check("st_terr_clr", 32'(timeout_err), 32'd0);
    hi = 0;
    repeat (3) begin
      tick();
      if (dOutREQ) hi++;
    end
    do_start(16'd5, 8'h99);
    if (dOutREQ) hi++;
    check("st_req_held", 32'(hi), 32'd0);
    resp_en = 1'b1;
    wait_done("st_done_seen", 40);
    check("st_nwords", 32'(words.size()), 32'd2);
    check("st_w0", wq(0), 32'h40);
    check("st_w1", wq(1), 32'h41);
    check("st_ws",    32'(words_sent), 32'd2);
    check("st_ndone", 32'(done_cnt),   32'd1);

    // 6. Reset during WAITHI of word 2, then a fresh burst
    words.delete();
    done_cnt = 0;
    do_start(16'd4, 8'h20);
    n = 0;
    while (!(words_sent == 16'd1 && dOutREQ) && n < 30) begin
      tick();
      n++;
    end
    check("rm_reached", 32'(words_sent == 16'd1 && dOutREQ), 32'd1);
    rst = 1'b1;
    tick();
    check("rm_req",  32'(dOutREQ),     32'd0);
    check("rm_dout", 32'(dOUT),        32'h00);
    check("rm_busy", 32'(busy),        32'd0);
    check("rm_done", 32'(done),        32'd0);
    check("rm_terr", 32'(timeout_err), 32'd0);
    check("rm_ws",   32'(words_sent),  32'd0);
    rst = 1'b0;
    tick();
    check("rm_ndone", 32'(done_cnt), 32'd0);
    words.delete();
    do_start(16'd2, 8'h30);
    wait_done("rm_done_seen", 40);
    check("rm_nwords", 32'(words.size()), 32'd2);
    check("rm_w0", wq(0), 32'h30);
    check("rm_w1", wq(1), 32'h31);
    check("rm_ws2",    32'(words_sent), 32'd2);
    check("rm_ndone2", 32'(done_cnt),   32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
